// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types, constants and helpers for the dynamic branch
//                predictor (counter constants, index/tag extraction,
//                instruction size).
//  Revision    : 1.0  initial release
// ============================================================================
package bp_pkg;

  // RV32I instructions are always 4 bytes; fall-through PC is pc + INSN_SIZE
  localparam int unsigned INSN_SIZE = 4;

  // Operation applied to a saturating counter on update
  typedef enum logic [1:0] {
    CNT_OP_HOLD = 2'd0,
    CNT_OP_INC  = 2'd1,
    CNT_OP_DEC  = 2'd2,
    CNT_OP_SET  = 2'd3
  } cnt_op_e;

  // Strongly-taken value: all ones
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Weakly-taken value: MSB set, rest clear
  function automatic logic [31:0] cnt_wt(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Weakly-not-taken value: MSB clear, rest set
  function automatic logic [31:0] cnt_wnt(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Table index: pc[iw+1:2]
  function automatic logic [31:0] pc_index(input logic [63:0] pc, input int unsigned iw);
    logic [63:0] mask;
    mask = (64'd1 << iw) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  // BTB tag: pc[tw+iw+1:iw+2]
  function automatic logic [31:0] pc_tag(input logic [63:0] pc, input int unsigned iw,
                                         input int unsigned tw);
    logic [63:0] mask;
    mask = (64'd1 << tw) - 64'd1;
    return 32'((pc >> (iw + 2)) & mask);
  endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bp_sat_counter
//  Description : Combinational next-state function of a CNT_WIDTH saturating
//                up/down counter with a "set to max" operation.
//  Revision    : 1.0  initial release
// ============================================================================
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic [CNT_WIDTH-1:0] cnt_cur,
  input  cnt_op_e              op,
  output logic [CNT_WIDTH-1:0] cnt_nxt
);

  localparam logic [CNT_WIDTH-1:0] C_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  // Saturating increment/decrement, or jump straight to the strong-taken value
  always_comb begin
    cnt_nxt = cnt_cur;
    case (op)
      CNT_OP_INC: if (cnt_cur != C_MAX) cnt_nxt = cnt_cur + CNT_WIDTH'(1);
      CNT_OP_DEC: if (cnt_cur != '0)    cnt_nxt = cnt_cur - CNT_WIDTH'(1);
      CNT_OP_SET: cnt_nxt = C_MAX;
      default:    cnt_nxt = cnt_cur;
    endcase
  end

endmodule : bp_sat_counter
`default_nettype wire

// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_bht
//  Description : Direct-mapped BHT of saturating counters plus tagged BTB.
//                Predicts direction/target for the IF PC, resolves branches
//                and jumps in EX, produces redirect PC and IF/ID flushes.
//                Optional macro BP_PERF_CNT_EN adds perf_branches and
//                perf_mispredicts saturating event counters.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic                  ex_is_jump,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic [ADDR_WIDTH-1:0] ex_pred_target,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  IF_flush,
  output logic                  ID_flush
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts
`endif
);

  localparam int unsigned          ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] C_WNT   = CNT_WIDTH'(cnt_wnt(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] C_WT    = CNT_WIDTH'(cnt_wt(CNT_WIDTH));

  // Table state (flop arrays)
  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
  logic [TAG_WIDTH-1:0]  tag_d    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_d [ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_q    [ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_d    [ENTRIES];

  logic [INDEX_WIDTH-1:0] if_idx, ex_idx;
  logic [TAG_WIDTH-1:0]   if_tag, ex_tag;
  logic                   rv;
  logic                   ex_hit;
  logic                   realloc;
  cnt_op_e                cnt_op;
  logic [CNT_WIDTH-1:0]   cnt_upd;
  logic [CNT_WIDTH-1:0]   cnt_new;

  assign if_idx = INDEX_WIDTH'(pc_index(64'(if_pc), INDEX_WIDTH));
  assign if_tag = TAG_WIDTH'(pc_tag(64'(if_pc), INDEX_WIDTH, TAG_WIDTH));
  assign ex_idx = INDEX_WIDTH'(pc_index(64'(ex_pc), INDEX_WIDTH));
  assign ex_tag = TAG_WIDTH'(pc_tag(64'(ex_pc), INDEX_WIDTH, TAG_WIDTH));

  // IF lookup: predict taken only on a valid tag hit with counter MSB set
  always_comb begin
    pred_taken  = valid_q[if_idx] & (tag_q[if_idx] == if_tag) & cnt_q[if_idx][CNT_WIDTH-1];
    pred_target = target_q[if_idx];
  end

  // EX resolve: compare the real outcome with what was predicted at fetch
  always_comb begin
    rv          = ex_valid & (ex_is_branch | ex_is_jump);
    mispredict  = rv & ((ex_taken != ex_pred_taken) |
                        (ex_taken & (ex_target != ex_pred_target)));
    redirect_pc = ex_taken ? ex_target : ex_pc + ADDR_WIDTH'(INSN_SIZE);
    IF_flush    = mispredict;
    ID_flush    = mispredict;
  end

  // Counter operation; a taken resolve that misses the BTB takes over the
  // entry, so a branch restarts its counter at weakly-taken instead
  always_comb begin
    ex_hit  = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
    realloc = ex_taken & ~ex_hit;
    if (ex_is_jump)    cnt_op = CNT_OP_SET;
    else if (ex_taken) cnt_op = CNT_OP_INC;
    else               cnt_op = CNT_OP_DEC;
  end

  bp_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sat_counter (
    .cnt_cur (cnt_q[ex_idx]),
    .op      (cnt_op),
    .cnt_nxt (cnt_upd)
  );

  assign cnt_new = (realloc & ~ex_is_jump) ? C_WT : cnt_upd;

  // Table next state: only a live branch/jump in EX writes its entry
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (rv) begin
      cnt_d[ex_idx] = cnt_new;
      if (ex_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
      end
    end
  end

  // Table registers; reset leaves every entry invalid and weakly-not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= C_WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  // Saturating event counters for resolves and mispredicts
  always_comb begin
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (rv && (perf_branches_q != '1))
      perf_branches_d = perf_branches_q + 32'd1;
    if (mispredict && (perf_mispredicts_q != '1))
      perf_mispredicts_d = perf_mispredicts_q + 32'd1;
  end

  // Event counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule : branch_predictor_bht
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_bht
//  Description : Self-checking bench for branch_predictor_bht: directed
//                scenarios plus randomized traffic against a table model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_predictor_bht;

  localparam int ENT  = 64;
  localparam int IW   = 6;
  localparam int CMAX = 3;
  localparam int CWT  = 2;
  localparam int CWNT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict, IF_flush, ID_flush;
  logic [31:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  branch_predictor_bht dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .IF_flush       (IF_flush),
    .ID_flush       (ID_flush)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: per-entry integer counter, valid, tag, target
  bit          m_v   [ENT];
  int          m_cnt [ENT];
  int unsigned m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_pb, m_pm;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> (IW + 2)) % 256;
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_v[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= CWT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_v[i] = 1'b0; m_cnt[i] = CWNT; m_tag[i] = 0; m_tgt[i] = '0;
    end
    m_pb = 0; m_pm = 0;
  endtask

  task automatic model_update();
    int i;
    bit hit;
    i   = idx_of(ex_pc);
    hit = m_v[i] && (m_tag[i] == tag_of(ex_pc));
    if (ex_is_jump)               m_cnt[i] = CMAX;
    else if (ex_taken && !hit)    m_cnt[i] = CWT;
    else if (ex_taken)            m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
    else                          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
    if (ex_taken) begin
      m_v[i] = 1'b1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target;
    end
  endtask

  task automatic drive(input bit v, input bit br, input bit jm, input logic [31:0] pc,
                       input bit tk, input logic [31:0] tg, input bit pt,
                       input logic [31:0] ptg, input logic [31:0] ifpc);
    ex_valid = v; ex_is_branch = br; ex_is_jump = jm; ex_pc = pc;
    ex_taken = tk; ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
    if_pc = ifpc;
  endtask

  // Check all outputs against the model mid-cycle, then clock the model
  task automatic step(input string tag);
    int i;
    bit ep, rv, em;
    logic [31:0] er;
    #4;
    i  = idx_of(if_pc);
    ep = model_pred(if_pc);
    chk({tag, ":pred"}, 64'(pred_taken), 64'(ep));
    if (ep) chk({tag, ":ptgt"}, 64'(pred_target), 64'(m_tgt[i]));
    rv = ex_valid && (ex_is_branch || ex_is_jump);
    em = rv && ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
    chk({tag, ":misp"}, 64'(mispredict), 64'(em));
    chk({tag, ":ifl"},  64'(IF_flush),   64'(em));
    chk({tag, ":idl"},  64'(ID_flush),   64'(em));
    if (em) begin
      er = ex_taken ? ex_target : ex_pc + 32'd4;
      chk({tag, ":redir"}, 64'(redirect_pc), 64'(er));
    end
`ifdef BP_PERF_CNT_EN
    chk({tag, ":pbr"}, 64'(perf_branches),    64'(m_pb));
    chk({tag, ":pmp"}, 64'(perf_mispredicts), 64'(m_pm));
`endif
    @(posedge clk);
    if (rv) begin
      model_update();
      m_pb++;
      if (em) m_pm++;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, '0, 0, '0, 0, '0, 32'h100);
    model_reset();
    #12;
    chk("rst_pred", 64'(pred_taken), 64'd0);
    chk("rst_misp", 64'(mispredict), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Taken branch at 0x100 predicted not-taken
    drive(1, 1, 0, 32'h100, 1, 32'h80, 0, '0, 32'h100);
    #2;
    chk("tp1_pred",  64'(pred_taken),  64'd0);
    chk("tp1_misp",  64'(mispredict),  64'd1);
    chk("tp1_redir", 64'(redirect_pc), 64'h80);
    chk("tp1_flush", 64'({IF_flush, ID_flush}), 64'd3);
    step("d1");

    // Next cycle the entry predicts taken to 0x80
    drive(0, 0, 0, '0, 0, '0, 0, '0, 32'h100);
    #2;
    chk("tp2_pred", 64'(pred_taken),  64'd1);
    chk("tp2_tgt",  64'(pred_target), 64'h80);
    step("d2");

    // Not-taken, predicted taken: fall-through redirect
    drive(1, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80, 32'h100);
    #2;
    chk("tp3_redir", 64'(redirect_pc), 64'h104);
    step("d3");
    drive(1, 1, 0, 32'h100, 0, 32'h80, 0, '0, 32'h100);
    step("d4");
    drive(1, 1, 0, 32'h100, 0, 32'h80, 0, '0, 32'h100);
    #2;
    chk("tp5_pred", 64'(pred_taken), 64'd0);
    chk("tp5_misp", 64'(mispredict), 64'd0);
    step("d5");

    // Aliasing PC differs only in tag
    drive(0, 0, 0, '0, 0, '0, 0, '0, 32'h200);
    step("d6");
    drive(1, 1, 0, 32'h200, 1, 32'h300, 0, '0, 32'h200);
    step("d7");
    drive(0, 0, 0, '0, 0, '0, 0, '0, 32'h200);
    #2;
    chk("tp7_pred", 64'(pred_taken), 64'd1);
    step("d8");
    drive(0, 0, 0, '0, 0, '0, 0, '0, 32'h100);
    step("d9");

    // JAL then JALR to a new target
    drive(1, 0, 1, 32'h200, 1, 32'h400, 1, 32'h300, 32'h200);
    step("d10");
    drive(1, 0, 1, 32'h200, 1, 32'h500, 1, 32'h400, 32'h200);
    #2;
    chk("tp10_misp",  64'(mispredict),  64'd1);
    chk("tp10_redir", 64'(redirect_pc), 64'h500);
    step("d11");

    // Killed branch in EX must not update or mispredict
    drive(0, 1, 0, 32'h200, 1, 32'h700, 0, '0, 32'h200);
    #2;
    chk("tp11_misp", 64'(mispredict), 64'd0);
    step("d12");
    drive(0, 0, 0, '0, 0, '0, 0, '0, 32'h200);
    #2;
    chk("tp12_tgt", 64'(pred_target), 64'h500);
    step("d13");

    // Fall-through wraps past the top of the address space
    drive(1, 1, 0, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 32'hFFFF_FFFC);
    #2;
    chk("wrap_redir", 64'(redirect_pc), 64'h0);
    step("d14");

    // Randomized traffic over a small PC pool so entries hit and alias
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pc, ifpc, tg, ptg;
      bit v, br, jm, tk, pt;
      int r;
      pc   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      ifpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      r    = $urandom_range(0, 9);
      br   = (r < 6);
      jm   = (r >= 6) && (r < 8);
      v    = ($urandom_range(0, 7) != 0);
      tk   = jm ? 1'b1 : 1'($urandom_range(0, 1));
      tg   = 32'h1000 + ($urandom_range(0, 3) << 4);
      if ($urandom_range(0, 1) == 0) begin
        pt  = model_pred(pc);
        ptg = m_tgt[idx_of(pc)];
      end else begin
        pt  = 1'($urandom_range(0, 1));
        ptg = 32'h1000 + ($urandom_range(0, 3) << 4);
      end
      drive(v, br, jm, pc, tk, tg, pt, ptg, ifpc);
      step("rnd");
    end

    // Reset asserted while an update is pending: the update is lost
    drive(1, 1, 0, 32'h100, 1, 32'h900, 0, '0, 32'h100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pred", 64'(pred_taken), 64'd0);
    @(posedge clk); #1;
    model_reset();
    drive(0, 0, 0, '0, 0, '0, 0, '0, 32'h100);
    rst_n = 1'b1;
    step("post_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_branch_predictor_bht
`default_nettype wire
